// File: rtl/float_struct.sv
// Shared single-precision FPU types: binary32 layout, adder state codes and
// extended-mantissa geometry used by the post-add normalize/round stage.
package float_struct;

  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned EXP_MAX    = 255;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned FRAC_W     = 23;
  localparam int unsigned EXT_MANT_W = 28;
  localparam int unsigned NORM_W     = EXT_MANT_W - 1;
  localparam int unsigned EXP_INT_W  = 10;
  localparam int unsigned LZC_W      = 5;

  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } states;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_point_num;

endpackage

// File: rtl/lzc27.sv
// Combinational leading-zero counter over the 27-bit hidden+fraction+GRS field.
// An all-zero input reports a count of 27 and raises o_zero.
module lzc27
  import float_struct::*;
(
  input  logic [NORM_W-1:0] i_data,
  output logic [LZC_W-1:0]  o_cnt,
  output logic              o_zero
);

  logic w_found;

  always_comb begin
    o_cnt   = LZC_W'(NORM_W);
    w_found = 1'b0;
    for (int i = NORM_W - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = LZC_W'(NORM_W - 1 - i);
        w_found = 1'b1;
      end
    end
    o_zero = ~|i_data;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalize and round-to-nearest-even stage of the binary32 FPU.
// Build option FP_DENORM_EN: produce subnormals instead of flushing underflow to zero.
module fp_normalize_round
  import float_struct::*;
#(
  parameter bit          OUT_REG = 1'b1,
  parameter logic [31:0] QNAN    = QNAN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic                  sign_i,
  input  logic [EXP_W-1:0]      exp_i,
  input  logic [EXT_MANT_W-1:0] mant_i,
  input  logic [1:0]            state_i,
  output logic [31:0]           result,
  output logic [1:0]            state,
  output logic                  res_vld
);

  // Stage 1: capture inputs with zero flag and leading-zero count
  logic [LZC_W-1:0]      w_lzc;
  logic                  w_lzc_zero;
  logic                  r1_vld;
  logic                  r1_sign;
  logic [EXP_W-1:0]      r1_exp;
  logic [EXT_MANT_W-1:0] r1_mant;
  logic [1:0]            r1_state;
  logic                  r1_zero;
  logic [LZC_W-1:0]      r1_lzc;

  lzc27 u_lzc27 (
    .i_data (mant_i[NORM_W-1:0]),
    .o_cnt  (w_lzc),
    .o_zero (w_lzc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld   <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_mant  <= '0;
      r1_state <= OK;
      r1_zero  <= 1'b0;
      r1_lzc   <= '0;
    end else begin
      r1_vld <= vld_i;
      if (vld_i) begin
        r1_sign  <= sign_i;
        r1_exp   <= exp_i;
        r1_mant  <= mant_i;
        r1_state <= state_i;
        r1_zero  <= w_lzc_zero & ~mant_i[EXT_MANT_W-1];
        r1_lzc   <= w_lzc;
      end
    end
  end

  // Stage 2: normalize so the hidden bit lands at bit 26; carry bit is folded away
  logic [NORM_W-1:0]           w2_mant;
  logic signed [EXP_INT_W-1:0] w2_exp;
  logic                        r2_vld;
  logic                        r2_sign;
  logic signed [EXP_INT_W-1:0] r2_exp;
  logic [NORM_W-1:0]           r2_mant;
  logic [1:0]                  r2_state;
  logic                        r2_zero;

  always_comb begin
    w2_mant = r1_mant[NORM_W-1:0] << r1_lzc;
    w2_exp  = $signed({2'b00, r1_exp}) - $signed({5'b00000, r1_lzc});
    if (r1_mant[EXT_MANT_W-1]) begin
      w2_mant = {r1_mant[EXT_MANT_W-1:2], r1_mant[1] | r1_mant[0]};
      w2_exp  = $signed({2'b00, r1_exp}) + 10'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vld   <= 1'b0;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_mant  <= '0;
      r2_state <= OK;
      r2_zero  <= 1'b0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_sign  <= r1_sign;
        r2_exp   <= w2_exp;
        r2_mant  <= w2_mant;
        r2_state <= r1_state;
        r2_zero  <= r1_zero;
      end
    end
  end

  // Stage 3: round to nearest even and pack with exception priority
  logic                        w_ru;
  logic                        w_mant_ovf;
  logic [FRAC_W-1:0]           w_frac;
  logic signed [EXP_INT_W-1:0] w_exp_r;
  float_point_num              w3_res;
  logic [1:0]                  w3_state;

  assign w_ru       = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
  assign w_mant_ovf = w_ru & (&r2_mant[NORM_W-1:3]);
  assign w_frac     = r2_mant[NORM_W-2:3] + FRAC_W'(w_ru);
  assign w_exp_r    = r2_exp + (w_mant_ovf ? 10'sd1 : 10'sd0);

`ifdef FP_DENORM_EN
  logic signed [EXP_INT_W-1:0] w_sh_full;
  logic [LZC_W-1:0]            w_sh;
  logic [NORM_W-1:0]           w_dn_sh;
  logic                        w_dn_lost;
  logic [NORM_W-1:0]           w_dn;
  logic                        w_dn_ru;
  logic [FRAC_W:0]             w_dn_inc;

  // Shift to exponent 1 scale; everything pushed out collapses into sticky
  assign w_sh_full = 10'sd1 - r2_exp;
  assign w_sh      = (w_sh_full > 10'sd26) ? LZC_W'(26) : w_sh_full[LZC_W-1:0];
  assign w_dn_sh   = r2_mant >> w_sh;
  assign w_dn_lost = |(r2_mant & ~({NORM_W{1'b1}} << w_sh));
  assign w_dn      = {w_dn_sh[NORM_W-1:1], w_dn_sh[0] | w_dn_lost};
  assign w_dn_ru   = w_dn[2] & (w_dn[1] | w_dn[0] | w_dn[3]);
  assign w_dn_inc  = w_dn[NORM_W-1:3] + (FRAC_W+1)'(w_dn_ru);
`endif

  always_comb begin
    w3_res   = '{sign: r2_sign, exp: w_exp_r[EXP_W-1:0], frac: w_mant_ovf ? '0 : w_frac};
    w3_state = OK;
    if (r2_state == NAN) begin
      w3_res   = QNAN;
      w3_state = NAN;
    end else if (r2_state == INF) begin
      w3_res   = '{sign: r2_sign, exp: '1, frac: '0};
      w3_state = INF;
    end else if (r2_zero) begin
      w3_res   = '0;
      w3_state = NUL;
    end else if (w_exp_r >= $signed(EXP_INT_W'(EXP_MAX))) begin
      w3_res   = '{sign: r2_sign, exp: '1, frac: '0};
      w3_state = INF;
    end else if (r2_exp <= 10'sd0) begin
`ifdef FP_DENORM_EN
      // A carry into bit 23 of the increment naturally becomes exponent field 1
      w3_res = {r2_sign, 7'b0000000, w_dn_inc};
      if (w_dn_inc == '0) begin
        w3_state = NUL;
      end
`else
      w3_res   = {r2_sign, 31'h0};
      w3_state = NUL;
`endif
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          res_vld <= 1'b0;
          result  <= '0;
          state   <= OK;
        end else begin
          res_vld <= r2_vld;
          if (r2_vld) begin
            result <= w3_res;
            state  <= w3_state;
          end
        end
      end
    end else begin : g_out_comb
      // Stage-2 registers hold between samples, so the packed result holds too
      logic r_loaded;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_loaded <= 1'b0;
        end else if (r1_vld) begin
          r_loaded <= 1'b1;
        end
      end

      assign res_vld = r2_vld;
      assign result  = r_loaded ? w3_res : 32'h0;
      assign state   = r_loaded ? w3_state : 2'(OK);
    end
  endgenerate

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized self-checking bench for fp_normalize_round (OUT_REG=1) against a
// value-level reference model; honours FP_DENORM_EN the same way the design does.
module tb_fp_normalize_round;
  import float_struct::*;

  localparam int unsigned N_RAND = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_i;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [27:0] mant_i;
  logic [1:0]  state_i;
  logic [31:0] result;
  logic [1:0]  state;
  logic        res_vld;

  int n_checks = 0;
  int n_errors = 0;

  // Model pipeline: two in-flight stages plus the held output {state, result}
  logic        m_v1, m_v2, out_v;
  logic [33:0] m_res1, m_res2, hold;

  fp_normalize_round #(.OUT_REG(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (vld_i),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .mant_i  (mant_i),
    .state_i (state_i),
    .result  (result),
    .state   (state),
    .res_vld (res_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint round_keep(input longint m);
    longint keep, rem;
    keep = m >> 3;
    rem  = m & 7;
    if (rem > 4 || (rem == 4 && keep[0])) keep++;
    return keep;
  endfunction

  // Value-level reference: locate the MSB, normalize, then round on integers
  function automatic logic [33:0] ref_fn(input logic s, input logic [7:0] e_in,
                                         input logic [27:0] mant, input logic [1:0] st);
    longint m, keep;
    int p, e;
    if (st == NAN) return {NAN, QNAN_DEFAULT};
    if (st == INF) return {INF, s, 8'hFF, 23'h0};
    if (mant == 28'h0) return {NUL, 32'h0};
    p = 0;
    for (int i = 0; i < 28; i++) if (mant[i]) p = i;
    m = longint'(mant);
    e = int'(e_in) + p - 26;
    if (p == 27) m = (m >> 1) | (m & 1);
    else m = m << (26 - p);
    if (e <= 0) begin
`ifdef FP_DENORM_EN
      int sh;
      longint lost;
      sh = 1 - e;
      if (sh > 26) sh = 26;
      lost = ((m & ((longint'(1) << sh) - 1)) != 0) ? 1 : 0;
      m = (m >> sh) | lost;
      keep = round_keep(m);
      if (keep == 0) return {NUL, s, 31'h0};
      return {OK, s, 31'(keep)};
`else
      return {NUL, s, 31'h0};
`endif
    end
    keep = round_keep(m);
    if (keep == (longint'(1) << 24)) begin
      e++;
      keep = 0;
    end
    if (e >= 255) return {INF, s, 8'hFF, 23'h0};
    return {OK, s, 8'(e), 23'(keep)};
  endfunction

  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] e,
                      input logic [27:0] m, input logic [1:0] st);
    @(negedge clk);
    rst = r; vld_i = v; sign_i = s; exp_i = e; mant_i = m; state_i = st;
    @(posedge clk);
    if (r) begin
      m_v1 = 1'b0; m_v2 = 1'b0; out_v = 1'b0; hold = '0;
    end else begin
      out_v = m_v2;
      if (m_v2) hold = m_res2;
      m_v2   = m_v1;
      m_res2 = m_res1;
      m_v1   = v;
      if (v) m_res1 = ref_fn(s, e, m, st);
    end
    #1;
    check("res_vld", 32'(res_vld), 32'(out_v));
    check("result", result, hold[31:0]);
    check("state", 32'(state), 32'(hold[33:32]));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h0, 28'h0, OK);
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic [1:0] st,
                          input logic [31:0] want_res, input logic [1:0] want_st);
    step(1'b0, 1'b1, s, e, m, st);
    idle();
    idle();
    check({tag, "_vld"}, 32'(res_vld), 32'h1);
    check({tag, "_res"}, result, want_res);
    check({tag, "_st"}, 32'(state), 32'(want_st));
    idle();
    check({tag, "_vld_drop"}, 32'(res_vld), 32'h0);
  endtask

  initial begin
    logic [7:0] e;
    logic [1:0] st;
    m_v1 = 1'b0; m_v2 = 1'b0; out_v = 1'b0; hold = '0; m_res1 = '0; m_res2 = '0;
    rst = 1'b1; vld_i = 1'b0; sign_i = 1'b0; exp_i = '0; mant_i = '0; state_i = OK;

    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h0, 28'h0, OK);
    check("reset_result", result, 32'h0);
    check("reset_state", 32'(state), 32'(OK));
    check("reset_vld", 32'(res_vld), 32'h0);

    directed("carry",    1'b0, 8'd127, 28'h8000000, OK,  32'h4000_0000, OK);
    directed("lzc1",     1'b0, 8'd127, 28'h2000000, OK,  32'h3F00_0000, OK);
    directed("zero",     1'b0, 8'd127, 28'h0000000, OK,  32'h0000_0000, NUL);
    directed("cancel",   1'b1, 8'd100, 28'h0000000, OK,  32'h0000_0000, NUL);
    directed("tie_even", 1'b0, 8'd127, 28'h4000004, OK,  32'h3F80_0000, OK);
    directed("tie_odd",  1'b0, 8'd127, 28'h400000C, OK,  32'h3F80_0002, OK);
    directed("rnd_ovf",  1'b0, 8'd127, 28'h7FFFFFC, OK,  32'h4000_0000, OK);
    directed("ovf",      1'b0, 8'd254, 28'hFFFFFFF, OK,  32'h7F80_0000, INF);
    directed("nan",      1'b1, 8'd3,   28'h0000123, NAN, 32'h7FC0_0000, NAN);
    directed("inf_in",   1'b1, 8'd10,  28'h0000005, INF, 32'hFF80_0000, INF);
`ifdef FP_DENORM_EN
    directed("uflow",    1'b0, 8'd1,   28'h2000000, OK,  32'h0040_0000, OK);
`else
    directed("uflow",    1'b0, 8'd1,   28'h2000000, OK,  32'h0000_0000, NUL);
`endif

    // Ten back-to-back samples
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'(i), 8'(120 + i), 28'($urandom) | 28'h4000000, OK);
    repeat (3) idle();

    // Reset with two samples in flight
    step(1'b0, 1'b1, 1'b0, 8'd127, 28'h8000000, OK);
    step(1'b0, 1'b1, 1'b1, 8'd130, 28'h4000000, OK);
    step(1'b1, 1'b0, 1'b0, 8'h0, 28'h0, OK);
    check("rst_flight_vld", 32'(res_vld), 32'h0);
    check("rst_flight_res", result, 32'h0);
    repeat (4) idle();

    for (int i = 0; i < N_RAND; i++) begin
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom);
        1:       e = 8'($urandom_range(0, 30));
        2:       e = 8'($urandom_range(240, 255));
        default: e = 8'($urandom_range(120, 135));
      endcase
      case ($urandom_range(0, 15))
        0:       st = NAN;
        1:       st = INF;
        default: st = OK;
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom), e,
           28'($urandom) >> $urandom_range(0, 28), st);
    end
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
